pcm_alaw_codec_stream: RTL
==========================

Name: pcm_alaw_codec_stream

Overview:
- Pipelined, parametrised G.711 A-law codec with valid/ready streaming on both sides; the next generation of the combinational PCM expander.
- Per transfer, `in_mode` selects the direction: expand (8-bit code to linear) or compress (13-bit linear to 8-bit code).
- Adds a selectable output width, sign-magnitude or two's-complement linear format, optional even-bit inversion, a channel tag passthrough and a transfer counter.
- Sits between the FSK/Hamming framing path and the sample-side logic.

Parameters:
- OUT_W, 8: linear output width (8..13); the expanded 13-bit value is truncated to its top OUT_W bits.
- SIGNED_FMT, 0: linear format. 0 = sign-magnitude (bit12 = sign bit); 1 = two's complement.
- INVERT, 0: 1 = XOR code with 8'h55 on the code side (decode input, encode output).
- CH_W, 2: channel tag width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept an input sample
- in_mode  in  1  0 = decode (use in_data[7:0]); 1 = encode (use in_data[12:0])
- in_data  in  13  code or linear sample
- in_ch  in  CH_W  channel tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_mode  out  1  mode of the result
- out_data  out  13  decode: OUT_W result in [OUT_W-1:0], upper bits zero (SIGNED_FMT=0) or sign-extended (SIGNED_FMT=1); encode: code in [7:0], [12:8]=0
- out_ch  out  CH_W  tag of the result
- xfer_cnt  out  16  count of completed output transfers, saturating at 16'hFFFF

Behaviour:
- **Reset** (rst=1 at a clk edge) clears:
  - both stage valids;
  - out_valid, out_data, out_ch, out_mode, xfer_cnt to 0;
  - in-flight samples are discarded.
- **Pipeline and flow control:** two register stages, S1 = expand/compress and S2 = format/truncate/output.
  - `en = out_ready | ~out_valid`; in_ready = en, combinational.
  - Handshakes: input accepted when in_valid & in_ready; output transfer when out_valid & out_ready.
  - When en=1 both stages advance; S1 valid loads in_valid.
  - Latency is 2 cycles from acceptance to out_valid with out_ready held high; throughput is 1 sample/cycle.
  - When out_ready=0 and out_valid=1, all state holds and the output is stable. Bubbles are not collapsed.
- **Decode:**
  - `c = in_data[7:0] ^ (INVERT ? 8'h55 : 0)`; s = c[6:4], m = c[3:0].
  - Magnitude (12 bits): s=0 → (m<<1)|1; s≥1 → (1<<(s+4)) | (m<<s) | (1<<(s-1)).
  - Sign-magnitude linear L = {c[7], mag}.
  - SIGNED_FMT=1: L = c[7] ? +mag : −mag (13-bit two's complement).
  - Result = L[12 -: OUT_W]; this is an arithmetic truncation for SIGNED_FMT=1.
- **Encode:**
  - SIGNED_FMT=0: sign = in_data[12], mag = in_data[11:0].
  - SIGNED_FMT=1: sign = ~in_data[12], mag = |in_data|, with −4096 clamped to 4095.
  - mag<32 → s=0, m=mag[4:1]. Otherwise s = (index of leading one) − 4, giving s in 1..7, and m = mag[s+3 -: 4].
  - code = {sign, s, m} ^ (INVERT ? 8'h55 : 0).
  - Encode(decode(x)) == x for all 256 codes in 13-bit/sign-magnitude configuration.
- **Transfer counter:** xfer_cnt increments on each output transfer and holds at 16'hFFFF.
- **Mode mix:** mode and channel tag travel with each sample; mixed modes back-to-back need no stall.
- **Reset mid-stall:** drops buffered results; in_ready=1 on the first cycle after reset.

Test Plan:
1. **Decode, default params:** send 8'h00, 8'hFF, 8'hA5 back-to-back, out_ready=1 → out_data 8'h00, 8'hFE, 8'h82 on cycles 2, 3, 4; xfer_cnt=3.
2. **Decode, OUT_W=13:**
   - SIGNED_FMT=0: 8'hA5 → 13'h1056.
   - SIGNED_FMT=1: 8'hA5 → 13'h0056; 8'h25 → 13'h1FAA.
3. **Encode and round trip:**
   - 13'h1056 → 8'hA5; 13'h1FFF → 8'hFF; 13'h0000 → 8'h00.
   - Sweep all 256 codes decode→encode (OUT_W=13) → identity.
4. **INVERT=1:**
   - Decode 8'hF0 (equivalent to 8'hA5) → 8'h82.
   - Encode 13'h1056 → 8'hF0.
5. **Backpressure:**
   - Stream 6 samples with out_ready toggling 1,0,0,1,… → no loss or duplication; order and in_ch tags preserved; out_data stable while stalled; in_ready=0 only when out_valid & ~out_ready.
6. **Reset and counter:**
   - Assert rst with both stages full and out_ready=0 → next cycle out_valid=0, xfer_cnt=0, in_ready=1.
   - Preload xfer_cnt near saturation (force) → holds at 16'hFFFF.

Source files
------------

// File: rtl/pcm_alaw_codec_stream.sv
// pcm_alaw_codec_stream: two-stage pipelined G.711 A-law expand/compress with valid/ready flow control
module pcm_alaw_codec_stream #(
  parameter int OUT_W      = 8,
  parameter int SIGNED_FMT = 0,
  parameter int INVERT     = 0,
  parameter int CH_W       = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_mode,
  input  logic [12:0]     in_data,
  input  logic [CH_W-1:0] in_ch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_mode,
  output logic [12:0]     out_data,
  output logic [CH_W-1:0] out_ch,
  output logic [15:0]     xfer_cnt
);
  localparam logic [7:0] MASK = (INVERT != 0) ? 8'h55 : 8'h00;
  localparam int SH = 13 - OUT_W;
  logic en;
  logic [7:0] dcode, ecode;
  logic [11:0] dmag, emag;
  logic [12:0] eabs, dec_out;
  logic [2:0] eseg;
  logic [3:0] emant;
  logic esign;
  logic signed [12:0] lin_s, shr_s;
  logic s1_valid_q, s1_valid_d, s1_mode_q, s1_mode_d;
  logic [CH_W-1:0] s1_ch_q, s1_ch_d, out_ch_q, out_ch_d;
  logic [12:0] s1_data_q, s1_data_d, out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, out_mode_q, out_mode_d;
  logic [15:0] xfer_cnt_q, xfer_cnt_d;
  assign en = out_ready | ~out_valid_q;
  assign in_ready = en;
  assign out_valid = out_valid_q;
  assign out_mode = out_mode_q;
  assign out_data = out_data_q;
  assign out_ch = out_ch_q;
  assign xfer_cnt = xfer_cnt_q;
  // S1: expand holds sign-magnitude {sign, mag}; compress holds the finished code
  always_comb begin
    dcode = in_data[7:0] ^ MASK;
    dmag = (dcode[6:4] == 3'd0) ? {7'd0, dcode[3:0], 1'b1}
                                : {6'd0, 1'b1, dcode[3:0], 1'b1} << (dcode[6:4] - 3'd1);
    esign = (SIGNED_FMT != 0) ? ~in_data[12] : in_data[12];
    eabs = (SIGNED_FMT != 0 && in_data[12]) ? -in_data : {1'b0, in_data[11:0]};
    emag = eabs[12] ? 12'hFFF : eabs[11:0];
    eseg = 3'd0;
    for (int i = 5; i < 12; i++) if (emag[i]) eseg = 3'(i - 4);
    emant = 4'(emag >> ((eseg == 3'd0) ? 3'd1 : eseg));
    ecode = {esign, eseg, emant} ^ MASK;
    s1_valid_d = en ? in_valid : s1_valid_q;
    s1_mode_d = en ? in_mode : s1_mode_q;
    s1_ch_d = en ? in_ch : s1_ch_q;
    s1_data_d = en ? (in_mode ? {5'd0, ecode} : {dcode[7], dmag}) : s1_data_q;
  end
  // S2: arithmetic shift keeps two's-complement truncation sign-extended
  always_comb begin
    lin_s = s1_data_q[12] ? $signed({1'b0, s1_data_q[11:0]}) : -$signed({1'b0, s1_data_q[11:0]});
    shr_s = lin_s >>> SH;
    dec_out = (SIGNED_FMT != 0) ? shr_s : s1_data_q >> SH;
    out_valid_d = en ? s1_valid_q : out_valid_q;
    out_mode_d = en ? s1_mode_q : out_mode_q;
    out_ch_d = en ? s1_ch_q : out_ch_q;
    out_data_d = en ? (s1_mode_q ? s1_data_q : dec_out) : out_data_q;
    xfer_cnt_d = (out_valid_q & out_ready & ~&xfer_cnt_q) ? xfer_cnt_q + 16'd1 : xfer_cnt_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q <= 1'b0;
      s1_ch_q <= '0;
      s1_data_q <= '0;
      out_valid_q <= 1'b0;
      out_mode_q <= 1'b0;
      out_ch_q <= '0;
      out_data_q <= '0;
      xfer_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mode_q <= s1_mode_d;
      s1_ch_q <= s1_ch_d;
      s1_data_q <= s1_data_d;
      out_valid_q <= out_valid_d;
      out_mode_q <= out_mode_d;
      out_ch_q <= out_ch_d;
      out_data_q <= out_data_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
endmodule
